// File: rtl/jpeg_pkg.sv
// Shared JPEG constants: the Q50 luminance table (raster order) used by both the
// encoder quantizer and the decoder dequantizer, plus the float32 field layout.
package jpeg_pkg;

   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;
   localparam int FP_BIAS  = 127;

   typedef struct packed {
      logic                sign;
      logic [FP_EXP_W-1:0] exp;
      logic [FP_MAN_W-1:0] man;
   } fp32_t;

   localparam logic [7:0] Q50_TBL [64] = '{
      8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
      8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
      8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
      8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
      8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
      8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
      8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
      8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
   };

endpackage

// File: rtl/int16_to_fp32.sv
// Combinational int16 -> float32 conversion. Every int16 fits in the 24-bit
// significand, so the result is exact; zero maps to +0.0.
module int16_to_fp32
   import jpeg_pkg::*;
(
   input  logic signed [15:0] i_val,
   output fp32_t              o_fp
);

   logic                w_neg;
   logic                w_zero;
   logic [15:0]         w_mag;
   logic [3:0]          w_msb;
   logic [4:0]          w_sh;
   logic [FP_MAN_W-1:0] w_norm;
   logic [FP_EXP_W-1:0] w_exp;

   assign w_neg  = i_val[15];
   assign w_mag  = w_neg ? 16'(-i_val) : 16'(i_val);
   assign w_zero = (w_mag == 16'd0);

   // Leading-one detector: position of the highest set bit of the magnitude.
   always_comb begin
      w_msb = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (w_mag[i]) w_msb = 4'(i);
      end
   end

   // Shifting into a 23-bit field pushes the implicit leading one off the top.
   assign w_sh   = 5'(FP_MAN_W) - {1'b0, w_msb};
   assign w_norm = {7'd0, w_mag} << w_sh;
   assign w_exp  = w_zero ? '0 : 8'(FP_BIAS) + {4'd0, w_msb};

   assign o_fp = '{sign: w_neg, exp: w_exp, man: w_norm};

endmodule

// File: rtl/dqnt.sv
// JPEG dequantizer: coefficient * Q50[index], emitted as float32 (or raw int32).
// Three-stage valid-only pipeline, no backpressure; index tracks raster position.
module dqnt
   import jpeg_pkg::*;
#(
   parameter bit OUT_FLOAT = 1'b1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  din,
   input  logic        din_valid,
   input  logic        din_sob,
   output logic [31:0] dout,
   output logic        dout_valid,
   output logic [5:0]  dout_idx,
   output logic        dout_last,
   output logic        blk_err
);

   logic [5:0]         r_q_cnt;
   logic [5:0]         w_idx;

   logic               r_s1_vld;
   logic signed [7:0]  r_s1_din;
   logic [5:0]         r_s1_idx;
   logic [7:0]         r_s1_q;

   logic               r_s2_vld;
   logic signed [15:0] r_s2_p;
   logic [5:0]         r_s2_idx;

   logic signed [15:0] w_prod;
   fp32_t              w_fp;
   logic [31:0]        w_res;

   assign w_idx = din_sob ? 6'd0 : r_q_cnt;

   // Raster index counter and sticky resync error; 6-bit wrap gives 63 -> 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q_cnt <= 6'd0;
         blk_err <= 1'b0;
      end else if (din_valid) begin
         r_q_cnt <= w_idx + 6'd1;
         if (din_sob && (r_q_cnt != 6'd0)) blk_err <= 1'b1;
      end
   end

   // S1: capture the coefficient, its index and the matching quantizer step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_vld <= 1'b0;
         r_s1_din <= '0;
         r_s1_idx <= '0;
         r_s1_q   <= '0;
      end else begin
         r_s1_vld <= din_valid;
         if (din_valid) begin
            r_s1_din <= din;
            r_s1_idx <= w_idx;
            r_s1_q   <= Q50_TBL[w_idx];
         end
      end
   end

   // Signed x unsigned; the largest magnitude (128*121) fits comfortably in 16 bits.
   assign w_prod = 16'(r_s1_din) * $signed({8'd0, r_s1_q});

   // S2: register the product.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_vld <= 1'b0;
         r_s2_p   <= '0;
         r_s2_idx <= '0;
      end else begin
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_s2_p   <= w_prod;
            r_s2_idx <= r_s1_idx;
         end
      end
   end

   int16_to_fp32 u_cvt (
      .i_val (r_s2_p),
      .o_fp  (w_fp)
   );

   assign w_res = OUT_FLOAT ? 32'(w_fp) : {{16{r_s2_p[15]}}, r_s2_p};

   // S3: output register; data and index hold while no sample is presented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_idx   <= '0;
         dout_last  <= 1'b0;
      end else begin
         dout_valid <= r_s2_vld;
         dout_last  <= r_s2_vld && (r_s2_idx == 6'd63);
         if (r_s2_vld) begin
            dout     <= w_res;
            dout_idx <= r_s2_idx;
         end
      end
   end

endmodule

// File: tb/tb_dqnt.sv
// Directed and table-driven bench for dqnt: float and int32 builds side by side,
// scored against an independent double-precision model of (float)(din*Q50[idx]).
module tb_dqnt;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  din = 8'd0;
   logic        din_valid = 1'b0;
   logic        din_sob = 1'b0;

   logic [31:0] f_dout, i_dout;
   logic        f_vld, i_vld, f_last, i_last, f_err, i_err;
   logic [5:0]  f_idx, i_idx;

   always #5 clk = ~clk;

   dqnt #(.OUT_FLOAT(1'b1)) u_flt (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_sob(din_sob),
      .dout(f_dout), .dout_valid(f_vld), .dout_idx(f_idx), .dout_last(f_last),
      .blk_err(f_err)
   );

   dqnt #(.OUT_FLOAT(1'b0)) u_int (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_sob(din_sob),
      .dout(i_dout), .dout_valid(i_vld), .dout_idx(i_idx), .dout_last(i_last),
      .blk_err(i_err)
   );

   localparam logic [7:0] QT [64] = '{
      8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
      8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
      8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
      8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
      8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
      8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
      8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
      8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
   };

   typedef struct {
      logic [31:0] flt;
      logic [31:0] ival;
      logic [5:0]  idx;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [7:0]  din;
      int          idx;
      logic [31:0] eflt;
      logic [31:0] eint;
   } vec_t;

   exp_t q[$];
   vec_t vt[6];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   m_cnt = 0;

   function automatic logic [31:0] fmodel(input int p);
      real         r;
      logic [63:0] b;
      logic [10:0] e11;
      if (p == 0) return 32'h0;
      r   = real'(p);
      b   = $realtobits(r);
      e11 = b[62:52] - 11'd896;
      return {b[63], e11[7:0], b[51:29]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic s);
      exp_t             e;
      logic signed [7:0] ds;
      int               idx;
      int               p;
      ds    = d;
      idx   = s ? 0 : m_cnt;
      p     = int'(ds) * int'(QT[idx]);
      e.flt = fmodel(p);
      e.ival = p;
      e.idx = 6'(idx);
      e.cyc = cyc + 3;
      q.push_back(e);
      m_cnt = s ? 1 : (m_cnt + 1) % 64;
   endtask

   task automatic sb_check();
      exp_t e;
      if (f_vld) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious: dout_valid=1 with nothing outstanding (cyc %0d)", cyc);
         end else begin
            e = q.pop_front();
            chk("latency", 32'(cyc), 32'(e.cyc));
            chk("dout_flt", f_dout, e.flt);
            chk("dout_idx", 32'(f_idx), 32'(e.idx));
            chk("dout_last", 32'(f_last), 32'(e.idx == 6'd63));
            chk("int_valid", 32'(i_vld), 32'd1);
            chk("dout_int", i_dout, e.ival);
            chk("int_idx", 32'(i_idx), 32'(e.idx));
         end
      end else begin
         chk("idle_last", 32'(f_last | i_last), 32'd0);
         if (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL missing: no dout_valid for idx %0d due at cyc %0d", e.idx, e.cyc);
         end
      end
   endtask

   task automatic tick(input logic v, input logic [7:0] d, input logic s);
      @(posedge clk);
      cyc++;
      #1;
      din_valid = v;
      din       = d;
      din_sob   = s;
      if (v) push(d, s);
      @(negedge clk);
      sb_check();
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 8'd0, 1'b0);
   endtask

   task automatic fill_to_end();
      int guard = 0;
      while (m_cnt != 0 && guard < 64) begin
         tick(1'b1, 8'd0, 1'b0);
         guard++;
      end
   endtask

   initial begin
      vt[0] = '{8'd3,   0,  32'h42400000, 32'h00000030};
      vt[1] = '{8'hFB,  2,  32'hC2480000, 32'hFFFFFFCE};
      vt[2] = '{8'h7F,  37, 32'h46584C00, 32'h00003613};
      vt[3] = '{8'h80,  53, 32'hC6720000, 32'hFFFFC380};
      vt[4] = '{8'h01,  63, 32'h42C60000, 32'h00000063};
      vt[5] = '{8'hFF,  1,  32'hC1300000, 32'hFFFFFFF5};

      // Reset state
      #12;
      chk("rst_dout", f_dout | i_dout, 32'd0);
      chk("rst_valid", 32'({f_vld, i_vld}), 32'd0);
      chk("rst_idx", 32'({f_idx, i_idx}), 32'd0);
      chk("rst_last_err", 32'({f_last, i_last, f_err, i_err}), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven single coefficients at chosen raster positions
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < vt[i].idx; k++) tick(1'b1, 8'd0, k == 0);
         tick(1'b1, vt[i].din, vt[i].idx == 0);
         idle(3);
         chk("vec_flt", f_dout, vt[i].eflt);
         chk("vec_int", i_dout, vt[i].eint);
         chk("vec_idx", 32'(f_idx), 32'(vt[i].idx));
         fill_to_end();
      end

      // 64 back-to-back zeros plus a 65th sample that wraps to index 0
      for (int k = 0; k < 64; k++) tick(1'b1, 8'd0, k == 0);
      tick(1'b1, 8'd0, 1'b0);
      idle(4);
      chk("wrap_idx", 32'(f_idx), 32'd0);
      chk("wrap_err", 32'(f_err), 32'd0);
      fill_to_end();

      // Three blocks of random data with random gaps
      for (int b = 0; b < 192; b++) begin
         tick(1'b1, 8'($urandom), (b % 64) == 0);
         idle(int'($urandom_range(0, 2)));
      end
      idle(3);
      chk("clean_err", 32'(f_err | i_err), 32'd0);

      // Resync mid-block sets the sticky error
      for (int k = 0; k < 20; k++) tick(1'b1, 8'd1, k == 0);
      tick(1'b1, 8'd2, 1'b1);
      tick(1'b1, 8'd1, 1'b0);
      idle(3);
      chk("resync_err", 32'(f_err), 32'd1);
      chk("resync_idx", 32'(f_idx), 32'd1);
      fill_to_end();
      for (int k = 0; k < 64; k++) tick(1'b1, 8'(k), k == 0);
      idle(3);
      chk("sticky_err", 32'(f_err & i_err), 32'd1);

      // Reset with samples in flight
      tick(1'b1, 8'd5, 1'b1);
      tick(1'b1, 8'd6, 1'b0);
      idle(2);
      chk("pre_rst_valid", 32'(f_vld), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_drop_valid", 32'({f_vld, i_vld}), 32'd0);
      q.delete();
      m_cnt = 0;
      idle(2);
      @(negedge clk);
      rst = 1'b0;
      idle(4);
      chk("rst_clear_err", 32'({f_err, i_err}), 32'd0);
      tick(1'b1, 8'd3, 1'b0);
      idle(3);
      chk("post_rst_idx", 32'(f_idx), 32'd0);
      chk("post_rst_flt", f_dout, 32'h42400000);
      tick(1'b1, 8'd0, 1'b0);
      tick(1'b1, 8'hFB, 1'b0);
      idle(3);
      chk("post_rst_int", i_dout, 32'hFFFFFFCE);
      chk("post_rst_flt2", f_dout, 32'hC2480000);
      fill_to_end();

      idle(5);
      chk("drain", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
